// File: rtl/prio_code_pkg.sv
// Shared definitions for the priority select encoder/decoder pair:
// code points, decoder FSM states and the code-to-select mapping.
package prio_code_pkg;

  localparam logic [1:0] CODE_SEL1 = 2'b00;
  localparam logic [1:0] CODE_SEL2 = 2'b01;
  localparam logic [1:0] CODE_SEL3 = 2'b10;
  localparam logic [1:0] CODE_NONE = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Returns {sel3, sel2, sel1}; CODE_NONE maps to no select at all.
  function automatic logic [2:0] decode_sel(input logic [1:0] c);
    logic [2:0] s;
    s = 3'b000;
    case (c)
      CODE_SEL1: s = 3'b001;
      CODE_SEL2: s = 3'b010;
      CODE_SEL3: s = 3'b100;
      default:   s = 3'b000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/prio_code_fifo.sv
// DEPTH x 2-bit synchronous code FIFO with wrap-bit pointers, flush and fill level.
module prio_code_fifo
  import prio_code_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [1:0]       push_data,
  input  logic             pop,
  output logic [1:0]       pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [1:0]       mem [DEPTH];
  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LVL_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/prio_code_decoder.sv
// Buffers 2-bit priority codes and replays each as a one-hot select held for
// HOLD_CYCLES clocks; re-encoding {sel1,sel2,sel3} gives back the accepted code.
module prio_code_decoder
  import prio_code_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HOLD_CYCLES = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             code_valid,
  input  logic [1:0]       code,
  output logic             code_ready,
  output logic             sel1,
  output logic             sel2,
  output logic             sel3,
  output logic             sel_valid,
  output logic             done,
  output logic [LVL_W-1:0] level,
  output logic             dbg_state
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             sv_q, sv_d;
  logic             full, empty, pop, hold_end;
  logic [1:0]       head;

  // Handshake: a code is taken at a rising edge where code_valid && code_ready;
  // the source must hold code stable while code_valid is high and code_ready low.
  assign code_ready = rst_n && !full && !flush;

  prio_code_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (code_valid && code_ready),
    .push_data (code),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign hold_end = (state_q == HOLD) && (cnt_q == '0);
  assign pop      = !flush && !empty && ((state_q == IDLE) || hold_end);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    sv_d    = sv_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = 3'b000;
      sv_d    = 1'b0;
    end else if (pop) begin
      // Reload on the final hold cycle so consecutive codes have no bubble.
      state_d = HOLD;
      cnt_d   = CNT_W'(HOLD_CYCLES - 1);
      sel_d   = decode_sel(head);
      sv_d    = 1'b1;
    end else if (hold_end) begin
      state_d = IDLE;
      sel_d   = 3'b000;
      sv_d    = 1'b0;
    end else if (state_q == HOLD) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 3'b000;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      sv_q    <= sv_d;
    end
  end

  assign sel1      = sel_q[0];
  assign sel2      = sel_q[1];
  assign sel3      = sel_q[2];
  assign sel_valid = sv_q;
  assign done      = hold_end;
  assign dbg_state = (state_q == HOLD);

endmodule

// File: tb/tb_prio_code_decoder.sv
// Bench for prio_code_decoder: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances,
// scoreboard of accepted codes compared against re-encoded selects.
module tb_prio_code_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0, code_valid = 1'b0;
  logic [1:0] code = 2'b00;
  logic       code_ready, sel1, sel2, sel3, sel_valid, done, dbg_state;
  logic [2:0] level;

  logic       flush_h1 = 1'b0, code_valid_h1 = 1'b0;
  logic [1:0] code_h1 = 2'b00;
  logic       code_ready_h1, sel1_h1, sel2_h1, sel3_h1, sel_valid_h1, done_h1, dbg_state_h1;
  logic [2:0] level_h1;

  logic [1:0] exp_q[$];
  logic [1:0] q1[$];
  int n_cmp = 0;
  int n_err = 0;
  logic accepted, hold_start, prev_valid, prev_done;
  logic [2:0] lvl_before;

  always #5 clk = ~clk;

  prio_code_decoder #(.DEPTH(4), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .code_valid(code_valid), .code(code),
    .code_ready(code_ready), .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .sel_valid(sel_valid), .done(done), .level(level), .dbg_state(dbg_state)
  );

  prio_code_decoder #(.DEPTH(4), .HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .rst_n(rst_n), .flush(flush_h1), .code_valid(code_valid_h1), .code(code_h1),
    .code_ready(code_ready_h1), .sel1(sel1_h1), .sel2(sel2_h1), .sel3(sel3_h1),
    .sel_valid(sel_valid_h1), .done(done_h1), .level(level_h1), .dbg_state(dbg_state_h1)
  );

  function automatic logic [1:0] enc(input logic a, input logic b, input logic c);
    if (a) return 2'b00;
    if (b) return 2'b01;
    if (c) return 2'b10;
    return 2'b11;
  endfunction

  // Advance one clock; records the accepted code and whether a new hold began.
  task automatic tick();
    #3;
    accepted = rst_n && code_valid && code_ready;
    if (accepted) exp_q.push_back(code);
    prev_valid = sel_valid;
    prev_done  = done;
    lvl_before = level;
    @(posedge clk);
    #1;
    hold_start = sel_valid && (!prev_valid || prev_done);
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if ({sel1, sel2, sel3, sel_valid, done} !== 5'b0) begin n_err++;
      $display("FAIL reset_outs: got %b exp 00000", {sel1, sel2, sel3, sel_valid, done}); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d exp 0", level); end
    n_cmp++; if (code_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b exp 0", code_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (code_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b exp 1", code_ready); end
  endtask

  task automatic test_single();
    logic [1:0] e;
    code_valid = 1'b1; code = 2'b01;
    tick();
    code_valid = 1'b0;
    n_cmp++; if (sel_valid !== 1'b0 || level !== 3'd1) begin n_err++;
      $display("FAIL single_latency: got valid=%b level=%0d exp valid=0 level=1", sel_valid, level); end
    tick();
    n_cmp++; if (hold_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b exp 1", hold_start); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
    n_cmp++; if (enc(sel1, sel2, sel3) !== e) begin n_err++;
      $display("FAIL single_code: got %b exp %b", enc(sel1, sel2, sel3), e); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      n_cmp++; if ({sel1, sel2, sel3} !== 3'b010 || sel_valid !== 1'b1) begin n_err++;
        $display("FAIL single_hold%0d: got sels=%b valid=%b exp 010/1", i, {sel1, sel2, sel3}, sel_valid); end
      n_cmp++; if (done !== (i == 3)) begin n_err++;
        $display("FAIL single_done%0d: got %b exp %b", i, done, (i == 3)); end
    end
    tick();
    n_cmp++; if (sel_valid !== 1'b0 || sel2 !== 1'b0 || dbg_state !== 1'b0) begin n_err++;
      $display("FAIL single_end: got valid=%b sel2=%b state=%b exp 0/0/0", sel_valid, sel2, dbg_state); end
  endtask

  task automatic test_burst();
    logic [1:0] codes[4];
    logic [1:0] e;
    int k = 0, holds = 0, busy = 0, last = 0;
    codes = '{2'b00, 2'b01, 2'b10, 2'b11};
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (k < 4) begin code_valid = 1'b1; code = codes[k]; end
      else code_valid = 1'b0;
      tick();
      if (accepted) k++;
      if (hold_start) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
        n_cmp++; if (enc(sel1, sel2, sel3) !== e) begin n_err++;
          $display("FAIL burst_code%0d: got %b exp %b", holds, enc(sel1, sel2, sel3), e); end
        if (holds > 0) begin
          n_cmp++; if (cyc - last !== 4) begin n_err++;
            $display("FAIL burst_spacing%0d: got %0d exp 4", holds, cyc - last); end
        end
        last = cyc;
        holds++;
      end
      if (sel_valid) busy++;
      n_cmp++; if ($countones({sel1, sel2, sel3}) > 1) begin n_err++;
        $display("FAIL burst_onehot: got %b exp at most one", {sel1, sel2, sel3}); end
      if (k == 4 && exp_q.size() == 0 && !sel_valid && holds > 0) break;
    end
    code_valid = 1'b0;
    n_cmp++; if (holds !== 4) begin n_err++; $display("FAIL burst_holds: got %0d exp 4", holds); end
    n_cmp++; if (busy !== 16) begin n_err++; $display("FAIL burst_busy: got %0d exp 16", busy); end
  endtask

  task automatic test_fill();
    logic [1:0] codes[6];
    logic [1:0] e;
    int k = 0;
    bit seen_full = 0;
    for (int i = 0; i < 6; i++) codes[i] = 2'($urandom_range(0, 3));
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (k < 6) begin code_valid = 1'b1; code = codes[k]; end
      else code_valid = 1'b0;
      tick();
      if (accepted) begin
        k++;
        if (k == 5) begin
          #1;
          n_cmp++; if (level !== 3'd4 || code_ready !== 1'b0) begin n_err++;
            $display("FAIL fill_full: got level=%0d ready=%b exp 4/0", level, code_ready); end
        end
        if (k == 6) begin
          n_cmp++; if (lvl_before !== 3'd3) begin n_err++;
            $display("FAIL fill_sixth_after_pop: got level=%0d exp 3", lvl_before); end
        end
      end
      if (level == 3'd4) begin
        seen_full = 1;
        n_cmp++; if (code_ready !== 1'b0) begin n_err++;
          $display("FAIL fill_ready_when_full: got %b exp 0 (done=%b)", code_ready, done); end
      end
      if (hold_start) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
        n_cmp++; if (enc(sel1, sel2, sel3) !== e) begin n_err++;
          $display("FAIL fill_code: got %b exp %b", enc(sel1, sel2, sel3), e); end
      end
      if (k == 6 && exp_q.size() == 0 && !sel_valid) break;
    end
    code_valid = 1'b0;
    n_cmp++; if (k !== 6 || !seen_full || exp_q.size() !== 0) begin n_err++;
      $display("FAIL fill_drain: got k=%0d full_seen=%0d left=%0d exp 6/1/0", k, seen_full, exp_q.size()); end
  endtask

  task automatic test_flush();
    logic [1:0] codes[4];
    logic [1:0] e;
    codes = '{2'b10, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
    for (int i = 0; i < 4; i++) begin
      code_valid = 1'b1; code = codes[i];
      tick();
      if (hold_start) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
        n_cmp++; if (enc(sel1, sel2, sel3) !== e || e !== 2'b10) begin n_err++;
          $display("FAIL flush_first_code: got %b exp 10", enc(sel1, sel2, sel3)); end
      end
    end
    n_cmp++; if (level !== 3'd3 || sel3 !== 1'b1) begin n_err++;
      $display("FAIL flush_pre: got level=%0d sel3=%b exp 3/1", level, sel3); end
    flush = 1'b1; code_valid = 1'b1; code = 2'b01;
    #1;
    n_cmp++; if (code_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b exp 0", code_ready); end
    tick();
    flush = 1'b0; code_valid = 1'b0;
    n_cmp++; if (level !== 3'd0 || {sel1, sel2, sel3, sel_valid, done, dbg_state} !== 6'b0) begin n_err++;
      $display("FAIL flush_post: got level=%0d outs=%b exp 0/000000", level,
               {sel1, sel2, sel3, sel_valid, done, dbg_state}); end
    exp_q.delete();
    repeat (3) tick();
    n_cmp++; if (level !== 3'd0 || sel_valid !== 1'b0) begin n_err++;
      $display("FAIL flush_no_push: got level=%0d valid=%b exp 0/0", level, sel_valid); end
  endtask

  task automatic test_hold1();
    logic [1:0] e;
    int k = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (k < 8) begin code_valid_h1 = 1'b1; code_h1 = 2'($urandom_range(0, 3)); end
      else code_valid_h1 = 1'b0;
      #3;
      if (k < 8) begin
        n_cmp++; if (code_ready_h1 !== 1'b1) begin n_err++;
          $display("FAIL h1_ready%0d: got %b exp 1", cyc, code_ready_h1); end
      end
      if (code_valid_h1 && code_ready_h1) begin q1.push_back(code_h1); k++; end
      @(posedge clk); #1;
      if (cyc >= 1 && cyc <= 8) begin
        e = (q1.size() > 0) ? q1.pop_front() : 2'bxx;
        n_cmp++; if (enc(sel1_h1, sel2_h1, sel3_h1) !== e || sel_valid_h1 !== 1'b1) begin n_err++;
          $display("FAIL h1_code%0d: got %b valid=%b exp %b/1", cyc, enc(sel1_h1, sel2_h1, sel3_h1), sel_valid_h1, e); end
        n_cmp++; if (done_h1 !== 1'b1) begin n_err++; $display("FAIL h1_done%0d: got %b exp 1", cyc, done_h1); end
      end
      n_cmp++; if (level_h1 > 3'd1) begin n_err++; $display("FAIL h1_level%0d: got %0d exp <=1", cyc, level_h1); end
    end
    n_cmp++; if (sel_valid_h1 !== 1'b0 || done_h1 !== 1'b0) begin n_err++;
      $display("FAIL h1_end: got valid=%b done=%b exp 0/0", sel_valid_h1, done_h1); end
  endtask

  task automatic test_reset_mid();
    code_valid = 1'b1; code = 2'b10;
    tick();
    code = 2'b00;
    tick();
    code_valid = 1'b0;
    tick();
    n_cmp++; if (sel_valid !== 1'b1 || level !== 3'd1) begin n_err++;
      $display("FAIL rmid_pre: got valid=%b level=%0d exp 1/1", sel_valid, level); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({sel1, sel2, sel3, sel_valid, done, dbg_state, code_ready} !== 7'b0 || level !== 3'd0) begin n_err++;
      $display("FAIL rmid_outs: got outs=%b level=%0d exp 0000000/0",
               {sel1, sel2, sel3, sel_valid, done, dbg_state, code_ready}, level); end
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++; if (level !== 3'd0 || sel_valid !== 1'b0) begin n_err++;
      $display("FAIL rmid_discard: got level=%0d valid=%b exp 0/0", level, sel_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fill();
    test_flush();
    test_hold1();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion exp finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
